// File: rtl/host_mem_arb_if.sv
// host_mem_arb_if -- burst memory-mapped bus bundle shared by the arbiter's
// source ports and its sink port.
//   master modport : drives address/burstcount/read/write/writedata/byteenable,
//                    receives waitrequest/readdata/readdatavalid
//   slave modport  : the mirror image
interface host_mem_arb_if #(
  parameter int ADDR_WIDTH      = 48,
  parameter int DATA_WIDTH      = 512,
  parameter int BURST_CNT_WIDTH = 7
) ();
  logic [ADDR_WIDTH-1:0]      address;
  logic [BURST_CNT_WIDTH-1:0] burstcount;
  logic                       read;
  logic                       write;
  logic [DATA_WIDTH-1:0]      writedata;
  logic [DATA_WIDTH/8-1:0]    byteenable;
  logic                       waitrequest;
  logic [DATA_WIDTH-1:0]      readdata;
  logic                       readdatavalid;

  modport master (
    output address, burstcount, read, write, writedata, byteenable,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, burstcount, read, write, writedata, byteenable,
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/host_mem_arb.sv
// host_mem_arb -- two-source weighted arbiter in front of one burst memory sink.
// s0 is the DMA source, s1 the kernel USM source. Read responses are steered
// back to the issuing source through an in-order tracking FIFO.
// Ports:
//   clk           single clock
//   reset_n       asynchronous active-low reset
//   s0, s1        source buses (slave side of host_mem_arb_if)
//   m             sink bus (master side of host_mem_arb_if)
//   rsp_fifo_full read tracking FIFO full
//
// state  | meaning
// IDLE   | nobody granted, no command on the sink
// OWN    | source g owns the sink, commands pass through
// WBURST | source g is mid write burst, grant locked until the last beat
module host_mem_arb #(
  parameter int ADDR_WIDTH      = 48,
  parameter int DATA_WIDTH      = 512,
  parameter int BURST_CNT_WIDTH = 7,
  parameter int RSP_FIFO_DEPTH  = 64,
  parameter int S0_WEIGHT       = 1,
  parameter int S1_WEIGHT       = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  host_mem_arb_if.slave   s0,
  host_mem_arb_if.slave   s1,
  host_mem_arb_if.master  m,
  output logic            rsp_fifo_full
);
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_OWN    = 2'd1;
  localparam logic [1:0] ST_WBURST = 2'd2;

  localparam int BW = BURST_CNT_WIDTH;
  localparam int PW = $clog2(RSP_FIFO_DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(RSP_FIFO_DEPTH);
  localparam logic [7:0]  W0 = 8'(S0_WEIGHT);
  localparam logic [7:0]  W1 = 8'(S1_WEIGHT);

  logic [1:0]    state, state_nx;
  logic          g, g_nx;
  logic [7:0]    credit, credit_nx;
  logic [BW-1:0] wbeats, wbeats_nx;

  logic [BW:0]   fifo_mem [RSP_FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count;
  logic [BW-1:0] rbeat;

  logic req0, req1, own_read, own_write, own_req, own_req_eff, oth_req;
  logic [BW-1:0] own_bc;
  logic [7:0] weight_g, credit_inc;
  logic granting, fifo_full, fifo_empty, accepted, own_wait;
  logic push, pop, rdv_ok, head_id;
  logic [BW-1:0] head_bc;

  assign req0 = s0.read | s0.write;
  assign req1 = s1.read | s1.write;

  assign own_read  = g ? s1.read  : s0.read;
  assign own_write = g ? s1.write : s0.write;
  assign own_bc    = g ? s1.burstcount : s0.burstcount;
  assign own_req   = own_read | own_write;
  assign oth_req   = g ? req0 : req1;

  assign fifo_full  = (count == DEPTH_C);
  assign fifo_empty = (count == '0);
  // A read stuck behind a full FIFO does not hold the grant against the other source.
  assign own_req_eff = own_write | (own_read & ~fifo_full);

  assign granting = (state != ST_IDLE);

  assign m.address    = g ? s1.address    : s0.address;
  assign m.burstcount = own_bc;
  assign m.writedata  = g ? s1.writedata  : s0.writedata;
  assign m.byteenable = g ? s1.byteenable : s0.byteenable;
  assign m.read       = (state == ST_OWN) & own_read & ~fifo_full;
  assign m.write      = granting & own_write;

  assign accepted = (m.read | m.write) & ~m.waitrequest;
  assign own_wait = ~granting | m.waitrequest |
                    (own_read & (fifo_full | (state == ST_WBURST)));

  assign s0.waitrequest = g ? 1'b1 : own_wait;
  assign s1.waitrequest = g ? own_wait : 1'b1;

  assign weight_g   = g ? W1 : W0;
  assign credit_inc = (credit < weight_g) ? credit + 8'd1 : credit;

  always_comb begin
    state_nx  = state;
    g_nx      = g;
    credit_nx = credit;
    wbeats_nx = wbeats;
    case (state)
      ST_IDLE: begin
        if (req0 | req1) begin
          state_nx  = ST_OWN;
          credit_nx = 8'd0;
          g_nx      = (req0 & req1) ? ~g : req1;
        end
      end
      ST_OWN: begin
        if (accepted) begin
          if (own_write && (own_bc > BW'(1))) begin
            state_nx  = ST_WBURST;
            wbeats_nx = own_bc - BW'(1);
            credit_nx = credit_inc;
          end else if (oth_req && (credit_inc >= weight_g)) begin
            g_nx      = ~g;
            credit_nx = 8'd0;
          end else begin
            credit_nx = credit_inc;
          end
        end else if (!own_req_eff) begin
          if (oth_req) begin
            g_nx      = ~g;
            credit_nx = 8'd0;
          end else if (!own_req) begin
            state_nx  = ST_IDLE;
            credit_nx = 8'd0;
          end
        end
      end
      ST_WBURST: begin
        if (accepted) begin
          wbeats_nx = wbeats - BW'(1);
          if (wbeats == BW'(1)) begin
            state_nx = ST_OWN;
            // credit was already charged when the burst command was taken
            if (oth_req && (credit >= weight_g)) begin
              g_nx      = ~g;
              credit_nx = 8'd0;
            end
          end
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= ST_IDLE;
      g      <= 1'b1;
      credit <= 8'd0;
      wbeats <= '0;
    end else begin
      state  <= state_nx;
      g      <= g_nx;
      credit <= credit_nx;
      wbeats <= wbeats_nx;
    end
  end

  // Response tracking: one entry {source, burstcount} per accepted read.
  assign head_id = fifo_mem[rd_ptr][BW];
  assign head_bc = fifo_mem[rd_ptr][BW-1:0];
  assign rdv_ok  = m.readdatavalid & ~fifo_empty;
  assign push    = m.read & ~m.waitrequest;
  assign pop     = rdv_ok & ((rbeat + BW'(1)) == head_bc);

  assign s0.readdata      = m.readdata;
  assign s1.readdata      = m.readdata;
  assign s0.readdatavalid = rdv_ok & ~head_id;
  assign s1.readdatavalid = rdv_ok & head_id;
  assign rsp_fifo_full    = fifo_full;

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {g, own_bc};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      rbeat  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
        rbeat  <= '0;
      end else if (rdv_ok) begin
        rbeat <= rbeat + BW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: tb/tb_host_mem_arb.sv
module tb_host_mem_arb;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = 7;

  logic clk = 1'b0;
  logic reset_n;
  logic full_a, full_b;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  host_mem_arb_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_CNT_WIDTH(BW)) a0 ();
  host_mem_arb_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_CNT_WIDTH(BW)) a1 ();
  host_mem_arb_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_CNT_WIDTH(BW)) am ();
  host_mem_arb_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_CNT_WIDTH(BW)) b0 ();
  host_mem_arb_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_CNT_WIDTH(BW)) b1 ();
  host_mem_arb_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_CNT_WIDTH(BW)) bm ();

  host_mem_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_CNT_WIDTH(BW)) dut (
    .clk(clk), .reset_n(reset_n), .s0(a0), .s1(a1), .m(am), .rsp_fifo_full(full_a));

  host_mem_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_CNT_WIDTH(BW),
                 .RSP_FIFO_DEPTH(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .s0(b0), .s1(b1), .m(bm), .rsp_fifo_full(full_b));

  task automatic init_all;
    a0.read = 0; a0.write = 0; a0.address = '0; a0.burstcount = 7'd1; a0.writedata = '0; a0.byteenable = '1;
    a1.read = 0; a1.write = 0; a1.address = '0; a1.burstcount = 7'd1; a1.writedata = '0; a1.byteenable = '1;
    b0.read = 0; b0.write = 0; b0.address = '0; b0.burstcount = 7'd1; b0.writedata = '0; b0.byteenable = '1;
    b1.read = 0; b1.write = 0; b1.address = '0; b1.burstcount = 7'd1; b1.writedata = '0; b1.byteenable = '1;
    am.waitrequest = 0; am.readdata = '0; am.readdatavalid = 0;
    bm.waitrequest = 0; bm.readdata = '0; bm.readdatavalid = 0;
  endtask

  task automatic issue_read(input bit src, input logic [AW-1:0] addr, input logic [BW-1:0] bc);
    bit w;
    bit done;
    done = 0;
    if (src) begin a1.read = 1; a1.address = addr; a1.burstcount = bc; end
    else     begin a0.read = 1; a0.address = addr; a0.burstcount = bc; end
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      w = src ? a1.waitrequest : a0.waitrequest;
      if (!w) begin
        checks++;
        if (am.read !== 1'b1 || am.address !== addr || am.burstcount !== bc) begin
          failures++;
          $display("FAIL issue_read_cmd got read=%b addr=%0h bc=%0d exp read=1 addr=%0h bc=%0d",
                   am.read, am.address, am.burstcount, addr, bc);
        end
      end
      @(posedge clk); #1;
      if (!w) done = 1;
    end
    a0.read = 0; a1.read = 0;
    checks++;
    if (!done) begin failures++; $display("FAIL issue_read_timeout got=0 exp=1"); end
  endtask

  task automatic test_reset;
    am.readdatavalid = 1;
    #1;
    checks++; if (a0.waitrequest !== 1'b1) begin failures++; $display("FAIL reset_s0_wait got=%b exp=1", a0.waitrequest); end
    checks++; if (a1.waitrequest !== 1'b1) begin failures++; $display("FAIL reset_s1_wait got=%b exp=1", a1.waitrequest); end
    checks++; if (am.read !== 1'b0 || am.write !== 1'b0) begin failures++; $display("FAIL reset_m_strobe got=%b%b exp=00", am.read, am.write); end
    checks++; if (full_a !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", full_a); end
    checks++; if (a0.readdatavalid !== 1'b0 || a1.readdatavalid !== 1'b0) begin failures++; $display("FAIL reset_rdv got=%b%b exp=00", a0.readdatavalid, a1.readdatavalid); end
    @(posedge clk); #1;
    reset_n = 1;
    am.readdatavalid = 0;
  endtask

  task automatic test_single_stream;
    int acc, cycles;
    bit w;
    acc = 0; cycles = 0;
    a1.read = 1; a1.burstcount = 7'd4; a1.address = '0;
    while (acc < 8 && cycles < 40) begin
      @(negedge clk);
      w = a1.waitrequest;
      if (!w) begin
        checks++;
        if (am.read !== 1'b1 || am.address !== 32'(acc * 64) || am.burstcount !== 7'd4) begin
          failures++;
          $display("FAIL stream_cmd got read=%b addr=%0h bc=%0d exp read=1 addr=%0h bc=4",
                   am.read, am.address, am.burstcount, acc * 64);
        end
      end
      @(posedge clk); #1;
      cycles++;
      if (!w) begin acc++; a1.address = 32'(acc * 64); end
    end
    a1.read = 0;
    checks++; if (cycles !== 9) begin failures++; $display("FAIL stream_cycles got=%0d exp=9", cycles); end
    for (int b = 0; b < 32; b++) begin
      am.readdatavalid = 1; am.readdata = 32'(b + 100);
      @(negedge clk);
      checks++;
      if (a1.readdatavalid !== 1'b1 || a0.readdatavalid !== 1'b0 || a1.readdata !== 32'(b + 100)) begin
        failures++;
        $display("FAIL stream_beat%0d got rdv0=%b rdv1=%b data=%0h exp rdv0=0 rdv1=1 data=%0h",
                 b, a0.readdatavalid, a1.readdatavalid, a1.readdata, b + 100);
      end
      @(posedge clk); #1;
    end
    am.readdatavalid = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_weights;
    int k, n0, n1, cycles;
    bit w0, w1;
    logic [DW-1:0] exp_d;
    k = 0; n0 = 0; n1 = 0; cycles = 0;
    a0.write = 1; a0.burstcount = 7'd1; a0.writedata = 32'h0000_0000;
    a1.write = 1; a1.burstcount = 7'd1; a1.writedata = 32'h1000_0000;
    while (k < 15 && cycles < 40) begin
      @(negedge clk);
      w0 = a0.waitrequest; w1 = a1.waitrequest;
      if (am.write === 1'b1) begin
        if (k % 5 == 0) begin exp_d = 32'(n0); n0++; end
        else            begin exp_d = 32'h1000_0000 + 32'(n1); n1++; end
        checks++;
        if (am.writedata !== exp_d) begin
          failures++;
          $display("FAIL weight_order%0d got=%0h exp=%0h", k, am.writedata, exp_d);
        end
        k++;
      end
      @(posedge clk); #1;
      cycles++;
      if (!w0) a0.writedata = a0.writedata + 1;
      if (!w1) a1.writedata = a1.writedata + 1;
    end
    a0.write = 0; a1.write = 0;
    checks++; if (cycles !== 16) begin failures++; $display("FAIL weight_cycles got=%0d exp=16", cycles); end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_write_burst;
    int beats, cyc;
    bit w0, w1, s1_next, s1_wait_bad, done;
    beats = 0; s1_next = 0; s1_wait_bad = 0; done = 0;
    a0.write = 1; a0.burstcount = 7'd16; a0.writedata = 32'hA000_0000;
    for (cyc = 0; cyc < 80 && !done; cyc++) begin
      am.waitrequest = (cyc % 2 == 0);
      if (cyc == 1) begin a1.write = 1; a1.burstcount = 7'd1; a1.writedata = 32'h5000_0000; end
      @(negedge clk);
      w0 = a0.waitrequest; w1 = a1.waitrequest;
      if (cyc >= 1 && beats < 16 && a1.waitrequest !== 1'b1) s1_wait_bad = 1;
      if (am.write === 1'b1 && am.waitrequest === 1'b0) begin
        if (beats < 16) begin
          checks++;
          if (am.writedata !== 32'hA000_0000 + 32'(beats)) begin
            failures++;
            $display("FAIL burst_beat%0d got=%0h exp=%0h", beats, am.writedata, 32'hA000_0000 + 32'(beats));
          end
          beats++;
        end else begin
          s1_next = (am.writedata === 32'h5000_0000);
          done = 1;
        end
      end
      @(posedge clk); #1;
      if (!w0 && a0.write) begin
        a0.writedata = a0.writedata + 1;
        if (a0.writedata == 32'hA000_0010) a0.write = 0;
      end
      if (!w1 && a1.write) a1.write = 0;
    end
    a0.write = 0; a1.write = 0; am.waitrequest = 0;
    checks++; if (beats !== 16) begin failures++; $display("FAIL burst_count got=%0d exp=16", beats); end
    checks++; if (s1_wait_bad) begin failures++; $display("FAIL burst_s1_wait got=0 exp=1"); end
    checks++; if (!s1_next) begin failures++; $display("FAIL burst_s1_next got=0 exp=1"); end
  endtask

  task automatic test_interleave;
    bit exp_src [6];
    exp_src = '{0, 0, 1, 1, 1, 0};
    issue_read(1'b0, 32'h100, 7'd2);
    issue_read(1'b1, 32'h200, 7'd3);
    issue_read(1'b0, 32'h300, 7'd1);
    for (int b = 0; b < 6; b++) begin
      am.readdatavalid = 1; am.readdata = 32'(b + 32'h77);
      @(negedge clk);
      checks++;
      if (a0.readdatavalid !== ~exp_src[b] || a1.readdatavalid !== exp_src[b]) begin
        failures++;
        $display("FAIL interleave_beat%0d got rdv0=%b rdv1=%b exp rdv0=%b rdv1=%b",
                 b, a0.readdatavalid, a1.readdatavalid, ~exp_src[b], exp_src[b]);
      end
      @(posedge clk); #1;
    end
    am.readdatavalid = 0;
  endtask

  task automatic test_fifo_full;
    int acc, cyc;
    bit w, done;
    acc = 0;
    b1.read = 1; b1.burstcount = 7'd1; b1.address = 32'h40;
    for (cyc = 0; cyc < 20 && acc < 4; cyc++) begin
      @(negedge clk);
      w = b1.waitrequest;
      @(posedge clk); #1;
      if (!w) begin acc++; b1.address = b1.address + 32'h40; end
    end
    checks++; if (acc !== 4) begin failures++; $display("FAIL full_fill got=%0d exp=4", acc); end
    @(negedge clk);
    checks++;
    if (bm.read !== 1'b0 || b1.waitrequest !== 1'b1 || full_b !== 1'b1) begin
      failures++;
      $display("FAIL full_stall got read=%b wait=%b full=%b exp read=0 wait=1 full=1", bm.read, b1.waitrequest, full_b);
    end
    @(posedge clk); #1;
    b0.write = 1; b0.burstcount = 7'd1; b0.writedata = 32'hCC;
    done = 0;
    for (cyc = 0; cyc < 20 && !done; cyc++) begin
      @(negedge clk);
      w = b0.waitrequest;
      if (!w) begin
        checks++;
        if (bm.write !== 1'b1 || bm.writedata !== 32'hCC) begin
          failures++;
          $display("FAIL full_write got write=%b data=%0h exp write=1 data=cc", bm.write, bm.writedata);
        end
      end
      @(posedge clk); #1;
      if (!w) done = 1;
    end
    b0.write = 0;
    checks++; if (!done) begin failures++; $display("FAIL full_write_timeout got=0 exp=1"); end
    bm.readdatavalid = 1; bm.readdata = 32'h55;
    @(negedge clk);
    checks++;
    if (b1.readdatavalid !== 1'b1 || b1.waitrequest !== 1'b1 || full_b !== 1'b1) begin
      failures++;
      $display("FAIL full_popcycle got rdv=%b wait=%b full=%b exp rdv=1 wait=1 full=1", b1.readdatavalid, b1.waitrequest, full_b);
    end
    @(posedge clk); #1;
    bm.readdatavalid = 0;
    @(negedge clk);
    checks++;
    if (b1.waitrequest !== 1'b0 || bm.read !== 1'b1 || full_b !== 1'b0) begin
      failures++;
      $display("FAIL full_release got wait=%b read=%b full=%b exp wait=0 read=1 full=0", b1.waitrequest, bm.read, full_b);
    end
    @(posedge clk); #1;
    b1.read = 0;
  endtask

  task automatic test_reset_mid;
    bit w, done;
    issue_read(1'b1, 32'h600, 7'd2);
    issue_read(1'b1, 32'h640, 7'd2);
    issue_read(1'b1, 32'h680, 7'd2);
    a0.write = 1; a0.burstcount = 7'd4; a0.writedata = 32'hB0;
    done = 0;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      w = a0.waitrequest;
      @(posedge clk); #1;
      if (!w) done = 1;
    end
    checks++; if (!done) begin failures++; $display("FAIL rstmid_first_beat got=0 exp=1"); end
    #2;
    checks++; if (am.write !== 1'b1) begin failures++; $display("FAIL rstmid_inburst got=%b exp=1", am.write); end
    reset_n = 0;
    am.readdatavalid = 1;
    #1;
    checks++;
    if (am.write !== 1'b0 || am.read !== 1'b0 || a0.waitrequest !== 1'b1 || a1.waitrequest !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_cmd got wr=%b rd=%b w0=%b w1=%b exp 0 0 1 1", am.write, am.read, a0.waitrequest, a1.waitrequest);
    end
    checks++;
    if (a0.readdatavalid !== 1'b0 || a1.readdatavalid !== 1'b0 || full_a !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_rsp got rdv0=%b rdv1=%b full=%b exp 0 0 0", a0.readdatavalid, a1.readdatavalid, full_a);
    end
    a0.write = 0;
    @(posedge clk); #1;
    reset_n = 1;
    @(negedge clk);
    checks++;
    if (a0.readdatavalid !== 1'b0 || a1.readdatavalid !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_discard got rdv0=%b rdv1=%b exp 0 0", a0.readdatavalid, a1.readdatavalid);
    end
    @(posedge clk); #1;
    am.readdatavalid = 0;
    a0.read = 1; a0.address = 32'h400; a0.burstcount = 7'd1;
    a1.read = 1; a1.address = 32'h500; a1.burstcount = 7'd1;
    done = 0;
    for (int c = 0; c < 10 && !done; c++) begin
      @(negedge clk);
      if (am.read === 1'b1) begin
        done = 1;
        checks++;
        if (am.address !== 32'h400 || a0.waitrequest !== 1'b0 || a1.waitrequest !== 1'b1) begin
          failures++;
          $display("FAIL rstmid_tie got addr=%0h w0=%b w1=%b exp addr=400 w0=0 w1=1", am.address, a0.waitrequest, a1.waitrequest);
        end
      end
      @(posedge clk); #1;
    end
    a0.read = 0; a1.read = 0;
    checks++; if (!done) begin failures++; $display("FAIL rstmid_tie_timeout got=0 exp=1"); end
  endtask

  initial begin
    reset_n = 0;
    init_all();
    #12;
    test_reset();
    test_single_stream();
    test_weights();
    test_write_burst();
    test_interleave();
    test_fifo_full();
    test_reset_mid();
    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
